// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory bus between mem_access_unit and memory
// Signals:
//   req   : access request, held until ack
//   we    : write enable (1 = store)
//   addr  : word-aligned byte address
//   be    : byte-lane enables
//   wdata : store data, replicated into the lanes selected by be
//   ack   : memory completion strobe
//   rdata : full read word returned with ack
// Modports: master = mem_access_unit side, slave = memory side.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - pipeline MEM-stage load/store unit with stalling memory handshake
// Ports:
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   MEM_mem_w     : store request (wins over load)
//   MEM_WDSel     : 2'b01 marks a load
//   MEM_dm_ctrl   : size/sign (000 word, 001 half s, 010 half u, 011 byte s, 100 byte u, others word)
//   MEM_aluout    : byte address
//   MEM_RD2       : store data
//   MEM_rdata     : aligned, extended load result (valid in DONE only)
//   MEM_stall     : freeze PC and pipeline registers
//   MEM_misalign  : misaligned access flag (no bus cycle issued)
//   MEM_stall_cnt : saturating count of stalled cycles
//   dmem          : memory bus, master side
module mem_access_unit (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_mem_w,
  input  logic [1:0]        MEM_WDSel,
  input  logic [2:0]        MEM_dm_ctrl,
  input  logic [31:0]       MEM_aluout,
  input  logic [31:0]       MEM_RD2,
  output logic [31:0]       MEM_rdata,
  output logic              MEM_stall,
  output logic              MEM_misalign,
  output logic [15:0]       MEM_stall_cnt,
  mem_access_unit_if.master dmem
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        access, is_word, is_half, misaligned, issue;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] rdata_q;
  logic [1:0]  lane_q;
  logic [2:0]  ctrl_q;
  logic        store_q;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Request decode and store lane formatting from the live pipeline inputs.
  always_comb begin
    access     = MEM_mem_w | (MEM_WDSel == 2'b01);
    is_half    = (MEM_dm_ctrl == 3'b001) | (MEM_dm_ctrl == 3'b010);
    is_word    = ~is_half & (MEM_dm_ctrl != 3'b011) & (MEM_dm_ctrl != 3'b100);
    misaligned = (is_word & (MEM_aluout[1:0] != 2'b00)) | (is_half & MEM_aluout[0]);
    if (is_word) begin
      be_nxt    = 4'b1111;
      wdata_nxt = MEM_RD2;
    end else if (is_half) begin
      be_nxt    = MEM_aluout[1] ? 4'b1100 : 4'b0011;
      wdata_nxt = {2{MEM_RD2[15:0]}};
    end else begin
      be_nxt    = 4'b0001 << MEM_aluout[1:0];
      wdata_nxt = {4{MEM_RD2[7:0]}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    MEM_stall    = 1'b0;
    MEM_misalign = 1'b0;
    issue        = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            MEM_misalign = 1'b1;
          end else begin
            MEM_stall = 1'b1;
            issue     = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        MEM_stall = 1'b1;
        if (dmem.ack) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are registered at issue and left untouched until ack, so the
  // memory sees a stable request for the whole WAIT phase. Size and lane are
  // captured too, so extraction in DONE does not depend on the pipeline inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem.req      <= 1'b0;
      dmem.we       <= 1'b0;
      dmem.addr     <= 32'h0;
      dmem.be       <= 4'h0;
      dmem.wdata    <= 32'h0;
      rdata_q       <= 32'h0;
      lane_q        <= 2'b00;
      ctrl_q        <= 3'b000;
      store_q       <= 1'b0;
      MEM_stall_cnt <= 16'h0;
    end else begin
      if (issue) begin
        dmem.req   <= 1'b1;
        dmem.we    <= MEM_mem_w;
        dmem.addr  <= {MEM_aluout[31:2], 2'b00};
        dmem.be    <= be_nxt;
        dmem.wdata <= wdata_nxt;
        lane_q     <= MEM_aluout[1:0];
        ctrl_q     <= MEM_dm_ctrl;
        store_q    <= MEM_mem_w;
      end else if ((state == WAIT) && dmem.ack) begin
        dmem.req <= 1'b0;
        rdata_q  <= dmem.rdata;
      end
      if (MEM_stall && (MEM_stall_cnt != 16'hFFFF))
        MEM_stall_cnt <= MEM_stall_cnt + 16'd1;
    end
  end

  // Load extraction: pick the addressed lane, then extend by the captured size code.
  always_comb begin
    lane_byte = rdata_q[{lane_q, 3'b000} +: 8];
    lane_half = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    MEM_rdata = 32'h0;
    if ((state == DONE) && !store_q) begin
      case (ctrl_q)
        3'b001:  MEM_rdata = {{16{lane_half[15]}}, lane_half};
        3'b010:  MEM_rdata = {16'h0, lane_half};
        3'b011:  MEM_rdata = {{24{lane_byte[7]}}, lane_byte};
        3'b100:  MEM_rdata = {24'h0, lane_byte};
        default: MEM_rdata = rdata_q;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, in port order: clk in 1 (rising-edge clock); reset in 1 (asynchronous, active-high).
REQ-002 Pipeline-side inputs SHALL be:
- MEM_mem_w in 1: store request.
- MEM_WDSel in 2: 2'b01 = load.
- MEM_dm_ctrl in 3: access size/sign.
- MEM_aluout in 32: byte address.
- MEM_RD2 in 32: store data.
REQ-003 Pipeline-side outputs SHALL be:
- MEM_rdata out 32: aligned, extended load result.
- MEM_stall out 1: hold the PC and all pipeline registers.
- MEM_misalign out 1: misaligned-access flag.
- MEM_stall_cnt out 16: saturating stall-cycle counter.
REQ-004 Memory-side ports SHALL be:
- dmem_req out 1
- dmem_we out 1
- dmem_addr out 32: word-aligned.
- dmem_be out 4
- dmem_wdata out 32
- dmem_ack in 1
- dmem_rdata in 32

Function
REQ-005 Access SHALL be defined as MEM_mem_w=1 or MEM_WDSel=2'b01; MEM_mem_w takes priority if both are set.
REQ-006 MEM_dm_ctrl encoding SHALL be: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; codes 101-111 SHALL be treated as word.
REQ-007 Misaligned SHALL mean: word with addr[1:0]!=0, or half with addr[0]!=0; bytes are never misaligned.
REQ-008 FSM states SHALL be IDLE, WAIT, DONE.
REQ-009 In IDLE with an aligned access, the block SHALL:
- assert MEM_stall combinationally;
- register dmem_addr={addr[31:2],2'b00}, dmem_we, dmem_be and dmem_wdata;
- set dmem_req=1 and enter WAIT at the next edge.
REQ-010 In IDLE with a misaligned access, the block SHALL:
- assert MEM_misalign combinationally;
- keep MEM_stall=0 and dmem_req=0, so no bus cycle occurs;
- drive MEM_rdata=0.
REQ-011 In WAIT, dmem_req and all registered bus outputs SHALL stay stable and MEM_stall SHALL stay 1 until dmem_ack=1 is sampled.
REQ-012 On the edge where dmem_ack=1 is sampled in WAIT, the block SHALL:
- capture dmem_rdata;
- clear dmem_req;
- enter DONE.
REQ-013 In DONE, MEM_stall SHALL be 0 for exactly one cycle and MEM_rdata SHALL present the extended load result; the next state SHALL be IDLE.
REQ-014 Minimum access latency SHALL be 3 cycles (IDLE, WAIT with immediate ack, DONE).
REQ-015 dmem_ack SHALL be ignored in IDLE and DONE.
REQ-016 Store byte enables SHALL be:
- word: 4'b1111, with wdata = RD2.
- half: 4'b0011 << (2·addr[1]), with RD2[15:0] replicated into both halves.
- byte: 4'b0001 << addr[1:0], with RD2[7:0] replicated into all four lanes.
REQ-017 Load extraction SHALL select the lane by addr[1:0] and then sign- or zero-extend per MEM_dm_ctrl.
REQ-018 MEM_rdata SHALL be 0 outside DONE and on stores.
REQ-019 MEM_stall_cnt SHALL increment on every cycle with MEM_stall=1 and saturate at 16'hFFFF.
REQ-020 The FSM SHALL drop no accesses; back-to-back accesses SHALL each pass through IDLE again.

Reset
REQ-021 While reset=1, the block SHALL immediately (asynchronously) force:
- state to IDLE;
- dmem_req, dmem_we, dmem_be and dmem_addr, dmem_wdata to 0;
- the captured read data to 0;
- MEM_stall_cnt to 0.
REQ-022 A reset asserted mid-access (in WAIT) SHALL abandon the access without waiting for dmem_ack; an ack arriving after reset is released SHALL be ignored.
REQ-023 After reset is released, the first access SHALL be evaluated in IDLE on the next rising edge.

Verification
REQ-024 Word load, addr=0x100, dm_ctrl=000, ack in the 2nd WAIT cycle, dmem_rdata=0xDEADBEEF -> dmem_addr=0x100, be=1111, MEM_stall high 3 cycles, MEM_rdata=0xDEADBEEF in DONE, MEM_stall_cnt=3.
REQ-025 Byte-signed load, addr=0x203, dm_ctrl=011, dmem_rdata=0x80112233 -> dmem_addr=0x200, MEM_rdata=0xFFFFFF80; repeating with dm_ctrl=100 -> MEM_rdata=0x00000080.
REQ-026 Half store, addr=0x302, RD2=0x0000ABCD, dm_ctrl=001 -> dmem_we=1, be=1100, wdata=0xABCDABCD, held stable until ack.
REQ-027 Word load at addr=0x105 -> MEM_misalign=1, MEM_stall=0, no dmem_req, MEM_rdata=0.
REQ-028 Reset pulsed in WAIT with no ack -> dmem_req=0 immediately, state IDLE, MEM_stall_cnt=0; a later stray ack causes no state change.
